// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared state encoding, header/CRC constants and the CRC-8 byte update
// used by the SPI egress frame packer.
package spi_frame_pkg;

    typedef enum logic [1:0] {IDLE, HDR, DATA, CRC} state_t;

    localparam logic [7:0] CRC8_POLY    = 8'h07;
    localparam int         HEADER_SEQ_W = 4;

    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        return c;
    endfunction

endpackage

// File: rtl/spi_crc8_byte.sv
// spi_crc8_byte: combinational CRC-8 (poly 0x07) update by one byte.
module spi_crc8_byte
    import spi_frame_pkg::*;
(
    input  logic [7:0] crc,
    input  logic [7:0] data,
    output logic [7:0] crc_next
);

    assign crc_next = crc8_update(crc, data);

endmodule

// File: rtl/spi_egress_frame_packer.sv
// spi_egress_frame_packer: packs wide AXIS words into header + payload byte frames.
// Defining SPI_PACKER_CRC8_EN appends a CRC-8 byte covering header and payload.
module spi_egress_frame_packer
    import spi_frame_pkg::*;
#(
    parameter int         DATA_WIDTH     = 32,
    parameter bit         BYTE_MSB_FIRST = 1'b1,
    parameter logic [3:0] HEADER_TAG     = 4'h5,
    parameter logic [7:0] IDLE_BYTE      = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [7:0]            m_axis_tuser,
    output logic [15:0]           frames_sent
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int IW     = $clog2(NBYTES) + 1;
`ifdef SPI_PACKER_CRC8_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    state_t                  state;
    logic [DATA_WIDTH-1:0]   sreg;
    logic [DATA_WIDTH-1:0]   sreg_next;
    logic [IW-1:0]           idx;
    logic [HEADER_SEQ_W-1:0] seq;
    logic [7:0]              head_byte;
    logic                    s_hs;
    logic                    m_hs;
    logic                    last_payload;

    assign s_hs         = s_axis_tvalid & s_axis_tready;
    assign m_hs         = m_axis_tvalid & m_axis_tready;
    assign head_byte    = BYTE_MSB_FIRST ? sreg[DATA_WIDTH-1 -: 8] : sreg[7:0];
    assign sreg_next    = BYTE_MSB_FIRST ? sreg << 8 : sreg >> 8;
    assign last_payload = idx == IW'(NBYTES - 1);
    assign m_axis_tuser = IDLE_BYTE;

`ifdef SPI_PACKER_CRC8_EN
    logic [7:0] crc;
    logic [7:0] crc_next;

    spi_crc8_byte u_crc (
        .crc      (crc),
        .data     (m_axis_tdata),
        .crc_next (crc_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            crc <= '0;
        else if (s_hs)
            crc <= '0;
        else if (m_hs)
            crc <= crc_next;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            s_axis_tready <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            seq           <= '0;
            frames_sent   <= '0;
            sreg          <= '0;
            idx           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_hs) begin
                        sreg          <= s_axis_tdata;
                        s_axis_tready <= 1'b0;
                        m_axis_tdata  <= {HEADER_TAG, seq};
                        m_axis_tvalid <= 1'b1;
                        state         <= HDR;
                    end else begin
                        s_axis_tready <= 1'b1;
                    end
                end
                HDR: begin
                    if (m_hs) begin
                        m_axis_tdata <= head_byte;
                        sreg         <= sreg_next;
                        idx          <= '0;
                        m_axis_tlast <= !CRC_EN && (NBYTES == 1);
                        state        <= DATA;
                    end
                end
                DATA: begin
                    if (m_hs) begin
                        if (!last_payload) begin
                            m_axis_tdata <= head_byte;
                            sreg         <= sreg_next;
                            idx          <= idx + 1'b1;
                            m_axis_tlast <= !CRC_EN && (idx == IW'(NBYTES - 2));
                        end
`ifdef SPI_PACKER_CRC8_EN
                        else begin
                            m_axis_tdata <= crc_next;
                            m_axis_tlast <= 1'b1;
                            state        <= CRC;
                        end
`endif
                    end
                end
                default: ;
            endcase
            // Frame completion overrides whatever the state branch scheduled.
            if (m_hs && m_axis_tlast) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                seq           <= seq + 1'b1;
                frames_sent   <= frames_sent + 1'b1;
                state         <= IDLE;
                s_axis_tready <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_egress_frame_packer.sv
// tb_spi_egress_frame_packer: directed bench with a byte-queue reference model of the frame format.
module tb_spi_egress_frame_packer;

    localparam int NB = 4;
`ifdef SPI_PACKER_CRC8_EN
    localparam int FL = NB + 2;
`else
    localparam int FL = NB + 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        m_tlast;
    logic [7:0]  m_tuser;
    logic [15:0] frames;

    logic [31:0] l_sdata;
    logic        l_svalid;
    logic        l_sready;
    logic [7:0]  l_mdata;
    logic        l_mvalid;
    logic        l_mlast;
    logic [7:0]  l_muser;
    logic [15:0] l_frames;

    always #5 clk = ~clk;

    spi_egress_frame_packer #(.DATA_WIDTH(32), .BYTE_MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .frames_sent(frames)
    );

    spi_egress_frame_packer #(.DATA_WIDTH(32), .BYTE_MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst),
        .s_axis_tdata(l_sdata), .s_axis_tvalid(l_svalid), .s_axis_tready(l_sready),
        .m_axis_tdata(l_mdata), .m_axis_tvalid(l_mvalid), .m_axis_tready(1'b1),
        .m_axis_tlast(l_mlast), .m_axis_tuser(l_muser), .frames_sent(l_frames)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out", nm);
    endtask

    // Bit-serial CRC-8, poly 0x07, MSB first.
    function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] b);
        logic [7:0] r;
        logic fbk;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fbk = r[7] ^ b[i];
            r = {r[6:0], 1'b0};
            if (fbk) r = r ^ 8'h07;
        end
        return r;
    endfunction

    logic [7:0] exp_d[$];
    bit         exp_l[$];
    logic [7:0] cap_d[$];
    bit         cap_l[$];
    logic [7:0] hdrs[$];
    int         acc_t[$];
    int         seq_m = 0;
    int         done_m = 0;
    int         fb = 0;
    int         cyc = 0;
    bit         bp = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_d;
    logic       prev_l;

    logic [7:0] msb_exp [5] = '{8'h50, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] lsb_exp [5] = '{8'h50, 8'hD4, 8'hC3, 8'hB2, 8'hA1};

    task automatic push_frame(input logic [31:0] w);
        logic [7:0] b;
        logic [7:0] c;
        c = 8'h00;
        b = {4'h5, 4'(seq_m)};
        exp_d.push_back(b);
        exp_l.push_back(1'b0);
        c = crc8(c, b);
        for (int i = 0; i < NB; i++) begin
            b = 8'(w >> (8 * (NB - 1 - i)));
            exp_d.push_back(b);
            exp_l.push_back((FL == NB + 1) && (i == NB - 1));
            c = crc8(c, b);
        end
`ifdef SPI_PACKER_CRC8_EN
        exp_d.push_back(c);
        exp_l.push_back(1'b1);
`endif
        seq_m = (seq_m + 1) % 16;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_tready = bp ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst) begin
            exp_d.delete();
            exp_l.delete();
            seq_m = 0;
            done_m = 0;
            fb = 0;
            prev_stall = 1'b0;
        end else begin
            chk("frames_sent", 32'(frames), 32'(done_m % 65536));
            chk("tuser", 32'(m_tuser), 32'hFF);
            if (m_tvalid) chk("s_tready_busy", 32'(s_tready), 0);
            if (prev_stall) begin
                chk("hold_valid", 32'(m_tvalid), 1);
                chk("hold_data", 32'(m_tdata), 32'(prev_d));
                chk("hold_last", 32'(m_tlast), 32'(prev_l));
            end
            if (s_tvalid && s_tready) begin
                push_frame(s_tdata);
                acc_t.push_back(cyc);
            end
            if (m_tvalid && m_tready) begin
                bit el;
                cap_d.push_back(m_tdata);
                cap_l.push_back(m_tlast);
                if (fb == 0) hdrs.push_back(m_tdata);
                if (exp_d.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%0h with no frame pending", m_tdata);
                    el = m_tlast;
                end else begin
                    el = exp_l.pop_front();
                    chk("byte", 32'(m_tdata), 32'(exp_d.pop_front()));
                    chk("last", 32'(m_tlast), 32'(el));
                end
                if (el) done_m++;
                fb = el ? 0 : fb + 1;
            end
            prev_stall = m_tvalid && !m_tready;
            prev_d = m_tdata;
            prev_l = m_tlast;
        end
    end

    task automatic send_word(input logic [31:0] w);
        int k;
        k = 0;
        @(posedge clk);
        #1;
        s_tvalid = 1'b1;
        s_tdata = w;
        do begin
            @(negedge clk);
            k++;
        end while (!s_tready && k < 500);
        if (!s_tready) fail_now("send_word");
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(!m_tvalid && s_tready && exp_d.size() == 0) && k < 2000);
        if (k >= 2000) fail_now("wait_idle");
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int k;
        logic [7:0] lcap[$];
        bit lcapl[$];
        s_tvalid = 1'b0;
        s_tdata = '0;
        l_svalid = 1'b0;
        l_sdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        chk("rst_m_tdata", 32'(m_tdata), 0);
        chk("rst_m_tlast", 32'(m_tlast), 0);
        chk("rst_frames", 32'(frames), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("s_tready_before_edge", 32'(s_tready), 0);
        @(negedge clk);
        chk("s_tready_after_edge", 32'(s_tready), 1);

        cap_d.delete();
        cap_l.delete();
        send_word(32'hA1B2C3D4);
        wait_idle();
        chk("f1_len", 32'(cap_d.size()), 32'(FL));
        for (int i = 0; i < 5; i++) chk("f1_byte", 32'(cap_d[i]), 32'(msb_exp[i]));
        chk("f1_last", 32'(cap_l[FL-1]), 1);
        chk("f1_not_last", 32'(cap_l[FL-2]), 0);
        chk("f1_frames", 32'(frames), 1);
`ifdef SPI_PACKER_CRC8_EN
        chk("crc_model_pin", 32'(crc8(crc8(8'h00, 8'h50), 8'h00)), 32'h0C);
`endif

        @(posedge clk);
        #1;
        l_svalid = 1'b1;
        l_sdata = 32'hA1B2C3D4;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!l_sready && k < 100);
        @(posedge clk);
        #1;
        l_svalid = 1'b0;
        k = 0;
        while (lcap.size() < FL && k < 100) begin
            @(negedge clk);
            k++;
            if (l_mvalid) begin
                lcap.push_back(l_mdata);
                lcapl.push_back(l_mlast);
            end
        end
        if (lcap.size() < FL) fail_now("lsb_frame");
        for (int i = 0; i < 5; i++) chk("lsb_byte", 32'(lcap[i]), 32'(lsb_exp[i]));
        chk("lsb_last", 32'(lcapl[FL-1]), 1);
        chk("lsb_tuser", 32'(l_muser), 32'hFF);
        @(negedge clk);
        chk("lsb_frames", 32'(l_frames), 1);

        do_reset();
        hdrs.delete();
        acc_t.delete();
        for (int i = 0; i < 17; i++) send_word($urandom());
        wait_idle();
        chk("b2b_count", 32'(hdrs.size()), 17);
        chk("b2b_hdr0", 32'(hdrs[0]), 32'h50);
        chk("b2b_hdr15", 32'(hdrs[15]), 32'h5F);
        chk("b2b_hdr16", 32'(hdrs[16]), 32'h50);
        for (int i = 1; i < 17; i++) chk("throughput", 32'(acc_t[i] - acc_t[i-1]), 32'(FL + 1));
        chk("b2b_frames", 32'(frames), 17);

        send_word(32'h11223344);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(m_tvalid && m_tdata == 8'h22) && k < 100);
        if (k >= 100) fail_now("midframe_wait");
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_s_tready", 32'(s_tready), 0);
        chk("mid_rst_m_tvalid", 32'(m_tvalid), 0);
        chk("mid_rst_m_tdata", 32'(m_tdata), 0);
        chk("mid_rst_m_tlast", 32'(m_tlast), 0);
        chk("mid_rst_frames", 32'(frames), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        hdrs.delete();
        send_word(32'h55667788);
        wait_idle();
        chk("post_rst_hdr", 32'(hdrs[0]), 32'h50);
        chk("post_rst_frames", 32'(frames), 1);

        bp = 1'b1;
        for (int i = 0; i < 100; i++) send_word($urandom());
        wait_idle();
        bp = 1'b0;
        wait_idle();
        chk("bp_frames", 32'(frames), 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
